// File: rtl/z3_to_z1_serializer.sv
// Polyphase-to-serial recombiner: one N-sample frame in, N serial samples out (oldest first).
// Optional completed-frame counter enabled by defining Z3TOZ1_FRAME_CNT_EN.
module z3_to_z1_serializer #(
    parameter int W = 11,
    parameter int N = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [W-1:0]   in_data [0:N-1],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic signed [W-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(N)-1:0]  out_phase,
    output logic                  out_first,
    output logic [15:0]           frame_cnt
);

    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] P_LAST = PW'(N - 1);

    logic signed [W-1:0] cur_q [0:N-1];
    logic signed [W-1:0] cur_d [0:N-1];
    logic signed [W-1:0] nxt_q [0:N-1];
    logic signed [W-1:0] nxt_d [0:N-1];
    logic                active_q, active_d;
    logic                nxt_valid_q, nxt_valid_d;
    logic [PW-1:0]       p_q, p_d;

    logic                accept;
    logic                xfer;
    logic                done;
    logic [PW-1:0]       rd_idx;

    assign in_ready  = !nxt_valid_q;
    assign out_valid = active_q;
    assign rd_idx    = P_LAST - p_q;
    assign out_data  = cur_q[rd_idx];
    assign out_phase = p_q;
    assign out_first = active_q && (p_q == '0);

    assign accept = in_valid && in_ready;
    assign xfer   = active_q && out_ready;
    assign done   = xfer && (p_q == P_LAST);

    always_comb begin
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        active_d    = active_q;
        nxt_valid_d = nxt_valid_q;
        p_d         = p_q;

        if (done) begin
            p_d = '0;
            if (nxt_valid_q) begin
                cur_d       = nxt_q;
                nxt_valid_d = 1'b0;
            end else if (accept) begin
                // Pending slot empty: the incoming frame goes straight into service.
                cur_d = in_data;
            end else begin
                active_d = 1'b0;
            end
        end else if (xfer) begin
            p_d = p_q + PW'(1);
        end

        if (accept && !active_q) begin
            cur_d    = in_data;
            active_d = 1'b1;
            p_d      = '0;
        end else if (accept && !done) begin
            nxt_d       = in_data;
            nxt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                cur_q[i] <= '0;
                nxt_q[i] <= '0;
            end
            active_q    <= 1'b0;
            nxt_valid_q <= 1'b0;
            p_q         <= '0;
        end else begin
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            active_q    <= active_d;
            nxt_valid_q <= nxt_valid_d;
            p_q         <= p_d;
        end
    end

`ifdef Z3TOZ1_FRAME_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (done) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_cnt = cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_z3_to_z1_serializer.sv
// Self-checking bench for z3_to_z1_serializer: directed scenarios plus randomized traffic
// compared against a sample-queue model of the serializer.
module tb_z3_to_z1_serializer;

    localparam int W  = 11;
    localparam int N  = 3;
    localparam int PW = $clog2(N);
    localparam int VW = 1 + 1 + PW + 1 + W + 16;

    typedef logic [N*W-1:0] frame_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [W-1:0]  in_data [0:N-1];
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PW-1:0]        out_phase;
    logic                 out_first;
    logic [15:0]          frame_cnt;

    z3_to_z1_serializer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_phase (out_phase),
        .out_first (out_first),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;

    // Model: frames waiting at the producer, and the serial samples still owed downstream.
    frame_t      src[$];
    int          q_data[$];
    int          q_phase[$];
    logic [15:0] m_cnt;

    function automatic frame_t mk(input int a0, input int a1, input int a2);
        frame_t f;
        f = '0;
        f[0*W +: W] = W'(a0);
        f[1*W +: W] = W'(a1);
        f[2*W +: W] = W'(a2);
        return f;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        for (int i = 0; i < N; i++) f[i*W +: W] = W'($urandom);
        return f;
    endfunction

    function automatic int frames_held();
        return (q_data.size() + N - 1) / N;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic          ev;
        logic [PW-1:0] ph;
        logic [W-1:0]  d;
        logic [15:0]   c;
        ev = (q_data.size() > 0);
        ph = '0;
        d  = '0;
        if (ev) begin
            ph = PW'(q_phase[0]);
            d  = W'(q_data[0]);
        end
`ifdef Z3TOZ1_FRAME_CNT_EN
        c = m_cnt;
`else
        c = 16'h0000;
`endif
        return {ev, (frames_held() < 2), ph, (ev && ph == '0), d, c};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        logic [W-1:0] d;
        d = (q_data.size() > 0) ? out_data : '0;
        return {out_valid, in_ready, out_phase, out_first, d, frame_cnt};
    endfunction

    // One clock: offer the head producer frame (if any), advance the model, end at the next negedge.
    task automatic step(input bit offer, input bit ordy);
        bit     acc, xf;
        frame_t f;
        in_valid = offer && (src.size() > 0);
        f = in_valid ? src[0] : '0;
        for (int i = 0; i < N; i++) in_data[i] = f[i*W +: W];
        out_ready = ordy;
        acc = in_valid && (frames_held() < 2);
        xf  = (q_data.size() > 0) && ordy;
        @(posedge clk);
        if (xf) begin
            if (q_phase[0] == N - 1) m_cnt = m_cnt + 16'd1;
            void'(q_data.pop_front());
            void'(q_phase.pop_front());
        end
        if (acc) begin
            void'(src.pop_front());
            for (int k = 0; k < N; k++) begin
                q_data.push_back(int'($signed(f[(N-1-k)*W +: W])));
                q_phase.push_back(k);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] rst_vec;
        rst_vec = {1'b0, 1'b1, PW'(0), 1'b0, W'(0), 16'h0000};
        #1 reset = 1'b1;
        #2;
        n_cmp++;
        if ({out_valid, in_ready, out_phase, out_first, out_data, frame_cnt} !== rst_vec) begin
            n_err++;
            $display("FAIL reset_async: got %h required %h",
                     {out_valid, in_ready, out_phase, out_first, out_data, frame_cnt}, rst_vec);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, out_phase, out_first, out_data, frame_cnt} !== rst_vec) begin
            n_err++;
            $display("FAIL reset_held: got %h required %h",
                     {out_valid, in_ready, out_phase, out_first, out_data, frame_cnt}, rst_vec);
        end
        reset = 1'b0;
        step(0, 1);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_idle: got %h required %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        int e[3] = '{7, -2, 3};
        src.push_back(mk(3, -2, 7));
        step(1, 1);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL single_model cyc %0d: got %h required %h", c, act_vec(), exp_vec());
            end
            n_cmp++;
            if (out_valid !== (c <= 3) || (c <= 3 && int'(out_data) !== e[c-1])) begin
                n_err++;
                $display("FAIL single_data cyc %0d: got v=%0b d=%0d required v=%0b d=%0d",
                         c, out_valid, out_data, (c <= 3), (c <= 3) ? e[c-1] : 0);
            end
            step(0, 1);
        end
    endtask

    task automatic test_back_to_back();
        int e[6] = '{3, 2, 1, 6, 5, 4};
        int got[$];
        src.push_back(mk(1, 2, 3));
        src.push_back(mk(4, 5, 6));
        step(1, 1);
        for (int c = 1; c <= 7; c++) begin
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL b2b_model cyc %0d: got %h required %h", c, act_vec(), exp_vec());
            end
            if (out_valid === 1'b1) got.push_back(int'(out_data));
            step(1, 1);
        end
        n_cmp++;
        if (got.size() != 6 || got[0] != e[0] || got[1] != e[1] || got[2] != e[2] ||
            got[3] != e[3] || got[4] != e[4] || got[5] != e[5]) begin
            n_err++;
            $display("FAIL b2b_stream: got %0d samples %p required 6 samples %p", got.size(), got, e);
        end
    endtask

    task automatic test_backpressure();
        int got[$];
        src.push_back(mk(10, 20, 30));
        src.push_back(rnd_frame());
        src.push_back(rnd_frame());
        step(1, 1);
        step(0, 1);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stall_model k %0d: got %h required %h", k, act_vec(), exp_vec());
            end
            n_cmp++;
            if (int'(out_data) !== 20 || out_phase !== PW'(1) || in_ready !== (k == 0)) begin
                n_err++;
                $display("FAIL stall_hold k %0d: got d=%0d ph=%0d rdy=%0b required d=20 ph=1 rdy=%0b",
                         k, out_data, out_phase, in_ready, (k == 0));
            end
            step(1, 0);
        end
        for (int c = 0; c < 20 && (q_data.size() > 0 || src.size() > 0); c++) begin
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stall_drain cyc %0d: got %h required %h", c, act_vec(), exp_vec());
            end
            if (out_valid === 1'b1) got.push_back(int'(out_data));
            step(1, 1);
        end
        n_cmp++;
        if (q_data.size() != 0 || src.size() != 0 || got.size() < 2 || got[0] != 20 || got[1] != 10) begin
            n_err++;
            $display("FAIL stall_resume: got left=%0d pend=%0d first=%p required left=0 pend=0 first 20,10",
                     q_data.size(), src.size(), got);
        end
    endtask

    task automatic test_signed();
        int e[3] = '{0, 1023, -1024};
        src.push_back(mk(-1024, 1023, 0));
        step(1, 1);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (act_vec() !== exp_vec() || int'(out_data) !== e[c]) begin
                n_err++;
                $display("FAIL signed cyc %0d: got %h d=%0d required %h d=%0d",
                         c, act_vec(), out_data, exp_vec(), e[c]);
            end
            step(0, 1);
        end
    endtask

    task automatic test_reset_mid();
        int e[3] = '{7, 8, 9};
        src.push_back(rnd_frame());
        src.push_back(rnd_frame());
        step(1, 1);
        step(1, 1);
        n_cmp++;
        if (out_phase !== PW'(1) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_setup: got ph=%0d rdy=%0b v=%0b required ph=1 rdy=0 v=1",
                     out_phase, in_ready, out_valid);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 16'h0 || out_phase !== '0) begin
            n_err++;
            $display("FAIL rstmid_async: got v=%0b rdy=%0b cnt=%0d ph=%0d required v=0 rdy=1 cnt=0 ph=0",
                     out_valid, in_ready, frame_cnt, out_phase);
        end
        src.delete();
        q_data.delete();
        q_phase.delete();
        m_cnt = 16'h0;
        @(negedge clk);
        reset = 1'b0;
        src.push_back(mk(9, 8, 7));
        step(1, 1);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (act_vec() !== exp_vec() || (c < 3 && int'(out_data) !== e[c])) begin
                n_err++;
                $display("FAIL rstmid_after cyc %0d: got %h d=%0d required %h d=%0d",
                         c, act_vec(), out_data, exp_vec(), (c < 3) ? e[c] : 0);
            end
            step(0, 1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if (src.size() < 3 && $urandom_range(1, 0) == 1) src.push_back(rnd_frame());
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h required %h", c, act_vec(), exp_vec());
            end
            step($urandom_range(3, 0) != 0, (c % 200 < 100) ? 1'b1 : ($urandom_range(2, 0) != 0));
        end
        for (int c = 0; c < 40 && (q_data.size() > 0 || src.size() > 0); c++) begin
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_drain cyc %0d: got %h required %h", c, act_vec(), exp_vec());
            end
            step(1, 1);
        end
        n_cmp++;
        if (q_data.size() != 0 || src.size() != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL random_empty: got left=%0d pend=%0d v=%0b required 0 0 0",
                     q_data.size(), src.size(), out_valid);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_cnt     = 16'h0;
        for (int i = 0; i < N; i++) in_data[i] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_signed();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/z3_to_z1_serializer.md
Name: z3_to_z1_serializer

Overview:
- Polyphase-to-serial recombiner. Inverse of the decimate-by-3 phase splitter.
- Accepts one frame of N parallel phase samples through a valid/ready handshake and emits them one sample per clk, oldest first, with valid/ready backpressure.
- Sits at the interpolation/output end of the IIR chain, after the slow-rate polyphase filter sections.
- Holds one frame in service plus one pending frame, so output can stream back to back.

Parameters:
- W, 11, sample width in bits (signed two's complement).
- N, 3, phases per frame; legal range 2..8.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N x W (unpacked array [0:N-1], signed)  frame; [0] = newest sample x[n], [N-1] = oldest x[n-N+1].
- in_valid  input  1  frame present on in_data.
- in_ready  output  1  block can accept a frame this cycle.
- out_data  output  W signed  serial sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_phase  output  $clog2(N)  index of the sample on out_data within its frame (0 = first emitted = in_data[N-1]).
- out_first  output  1  high when out_valid and out_phase==0.
- frame_cnt  output  16  completed-frame counter (see Optional Feature).

Behaviour:
- Storage:
  - cur[0:N-1] plus active flag = frame in service.
  - nxt[0:N-1] plus nxt_valid = pending frame.
  - phase counter p, range 0..N-1.
- Reset (async): active=0, nxt_valid=0, p=0, cur/nxt cleared to 0. Outputs during reset: out_valid=0, out_data=0, out_phase=0, out_first=0, in_ready=1, frame_cnt=0. Reset mid-frame discards both frames silently.
- in_ready = !nxt_valid (registered-state based; no combinational path from out_ready).
- Input accept = in_valid && in_ready:
  - If !active: cur<=in_data, active<=1, p<=0.
  - If active and not finishing this cycle: nxt<=in_data, nxt_valid<=1.
  - If active and finishing this cycle (transfer at p==N-1) with nxt empty: bypass, cur<=in_data, p<=0, active stays 1.
- out_valid = active; out_data = cur[N-1-p]; out_phase = p.
- Transfer = out_valid && out_ready:
  - p<N-1: p<=p+1.
  - p==N-1 (frame complete): if nxt_valid then cur<=nxt, nxt_valid<=0, p<=0; else if input accept this cycle, bypass as above; else active<=0, p<=0.
- Stall: while out_valid && !out_ready, out_data, out_phase and cur hold stable. A new frame may still land in nxt if empty.
- Latency: frame accepted at edge t; its first sample is valid in the cycle after t. Full-rate streaming, with no idle cycle between frames, when out_ready=1 and a frame is offered within N cycles.
- Full: nxt_valid=1, so in_ready=0. Input held by producer; no data loss, no overwrite.
- Empty: active=0, so out_valid=0. out_data shows stale cur[N-1-p] and is don't-care for checkers.
- No arithmetic: pure data movement, width W preserved, sign untouched.

Optional Feature:
- Macro: Z3TOZ1_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1 on every frame-complete transfer (p==N-1 && out_valid && out_ready). Wraps 16'hFFFF -> 0. Cleared by reset.
- Undefined: counter logic absent; frame_cnt tied to 16'h0000.
- Datapath and handshake identical in both builds.

Test Plan:
- Single frame, N=3, out_ready=1: in_data={[0]=3,[1]=-2,[2]=7} accepted at cycle 0. Out cycles 1..3 = 7,-2,3; out_phase 0,1,2; out_first only at cycle 1; out_valid low at cycle 4; frame_cnt=1 with macro, 0 without.
- Back-to-back: frames A={1,2,3} and B={4,5,6} offered continuously. Output 3,2,1,6,5,4 with no bubble. in_ready drops while B is pending and rises on the cycle A completes.
- Backpressure: out_ready=0 for 5 cycles starting at phase 1 of frame {10,20,30}. out_data stays 20 and out_phase stays 1 throughout the stall. A second frame is taken into nxt, then in_ready=0 and a third frame is blocked. Sequence resumes 10, then the second frame, with no loss.
- Signed extremes, W=11: frame {-1024,1023,0}. Output 0,1023,-1024 bit-exact.
- Reset mid-frame: assert reset at phase 1 with nxt full. Immediately out_valid=0, in_ready=1, frame_cnt=0. After release, a new frame {9,8,7} emits 7,8,9 with no stale samples.
- Counter wrap (macro defined): preload by streaming 65536 frames. frame_cnt returns to 0 and the next frame gives 1.
